// File: rtl/alu_if.sv
// alu_if: operand/opcode/result bundle for the 16-bit registered ALU.
//   A, B      16-bit operands (B[3:0] doubles as shift/rotate amount)
//   Opcode    4-bit operation select
//   Output    16-bit registered result
//   Zero, Negative, Carry, Overflow  registered status flags
// master: the side that drives operands (datapath / bench)
// slave : the ALU itself
interface alu_if;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  Opcode;
    logic [15:0] Output;
    logic        Zero;
    logic        Negative;
    logic        Carry;
    logic        Overflow;

    modport master (
        output A, B, Opcode,
        input  Output, Zero, Negative, Carry, Overflow
    );

    modport slave (
        input  A, B, Opcode,
        output Output, Zero, Negative, Carry, Overflow
    );
endinterface

// File: rtl/alu.sv
// alu: 16-bit arithmetic/logic unit with one cycle of latency.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears result and all flags
//   bus    alu_if.slave: A, B, Opcode in; Output, Zero, Negative, Carry,
//          Overflow out (all outputs are flops)
// Every edge samples A/B/Opcode together and registers the result with
// the flags derived from that same result.
module alu (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    logic [3:0]  amt_s;
    logic [16:0] sum_s;
    logic [16:0] diff_s;
    logic [16:0] sll_s;
    logic [16:0] srl_s;
    logic [16:0] sra_s;
    logic [31:0] rol_s;
    logic [31:0] ror_s;
    logic        lt_signed_s;

    logic [15:0] result_s;
    logic        carry_s;
    logic        overflow_s;

    assign amt_s  = bus.B[3:0];
    assign sum_s  = {1'b0, bus.A} + {1'b0, bus.B};
    // Bit 16 of the difference is the borrow (A < B unsigned).
    assign diff_s = {1'b0, bus.A} - {1'b0, bus.B};
    // Extra bit on the far side of each shift catches the last bit shifted
    // out; with a zero amount it stays 0, which is the required carry.
    assign sll_s  = {1'b0, bus.A} << amt_s;
    assign srl_s  = {bus.A, 1'b0} >> amt_s;
    assign sra_s  = $signed({bus.A, 1'b0}) >>> amt_s;
    // Rotates: shift a doubled copy and take the half that wraps around.
    assign rol_s  = {bus.A, bus.A} << amt_s;
    assign ror_s  = {bus.A, bus.A} >> amt_s;
    // Same-sign operands compare like unsigned; otherwise the negative one is smaller.
    assign lt_signed_s = (bus.A[15] ^ bus.B[15]) ? bus.A[15] : diff_s[16];

    // Operation select: result, carry and overflow for the current opcode.
    always_comb begin
        result_s   = 16'h0000;
        carry_s    = 1'b0;
        overflow_s = 1'b0;
        case (bus.Opcode)
            4'b0000: begin
                result_s   = sum_s[15:0];
                carry_s    = sum_s[16];
                overflow_s = (bus.A[15] == bus.B[15]) && (sum_s[15] != bus.A[15]);
            end
            4'b0001: begin
                result_s   = diff_s[15:0];
                carry_s    = diff_s[16];
                overflow_s = (bus.A[15] != bus.B[15]) && (diff_s[15] != bus.A[15]);
            end
            4'b0010: begin
                result_s = sll_s[15:0];
                carry_s  = sll_s[16];
            end
            4'b0011: result_s = bus.A & bus.B;
            4'b0100: result_s = bus.A | bus.B;
            4'b0101: result_s = bus.A ^ bus.B;
            4'b0110: result_s = ~(bus.A | bus.B);
            4'b0111: result_s = ~bus.A;
            4'b1000: begin
                result_s = srl_s[16:1];
                carry_s  = srl_s[0];
            end
            4'b1001: begin
                result_s = sra_s[16:1];
                carry_s  = sra_s[0];
            end
            4'b1010: result_s = rol_s[31:16];
            4'b1011: result_s = ror_s[15:0];
            4'b1100: result_s = {15'h0000, lt_signed_s};
            4'b1101: result_s = {15'h0000, diff_s[16]};
            4'b1110: result_s = bus.B;
            4'b1111: result_s = bus.A;
            default: begin
                result_s   = 16'h0000;
                carry_s    = 1'b0;
                overflow_s = 1'b0;
            end
        endcase
    end

    // Output register: result and flags captured together each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Output   <= 16'h0000;
            bus.Zero     <= 1'b0;
            bus.Negative <= 1'b0;
            bus.Carry    <= 1'b0;
            bus.Overflow <= 1'b0;
        end else begin
            bus.Output   <= result_s;
            bus.Zero     <= (result_s == 16'h0000);
            bus.Negative <= result_s[15];
            bus.Carry    <= carry_s;
            bus.Overflow <= overflow_s;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu (directed table, hand sequences for
// reset/latency, and randomized vectors against a reference model).
module tb_alu;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } vec_t;

    // Reference model written from the operation rules using integer arithmetic.
    // Returns {Output, Zero, Negative, Carry, Overflow}.
    function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int ua, ub, sa, sb, n, r, t;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = int'(b[3:0]);
        r  = 0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            4'd0: begin
                r = ua + ub; c = (r > 65535); r = r & 65535;
                t = sa + sb; v = (t > 32767) || (t < -32768);
            end
            4'd1: begin
                r = (ua - ub) & 65535; c = (ua < ub);
                t = sa - sb; v = (t > 32767) || (t < -32768);
            end
            4'd2: begin
                r = (ua << n) & 65535;
                c = (n != 0) && (((ua >> (16 - n)) & 1) == 1);
            end
            4'd3: r = ua & ub;
            4'd4: r = ua | ub;
            4'd5: r = ua ^ ub;
            4'd6: r = ~(ua | ub) & 65535;
            4'd7: r = ~ua & 65535;
            4'd8: begin
                r = ua >> n;
                c = (n != 0) && (((ua >> (n - 1)) & 1) == 1);
            end
            4'd9: begin
                r = (sa >>> n) & 65535;
                c = (n != 0) && (((ua >> (n - 1)) & 1) == 1);
            end
            4'd10: r = ((ua << n) | (ua >> (16 - n))) & 65535;
            4'd11: r = ((ua >> n) | (ua << (16 - n))) & 65535;
            4'd12: r = (sa < sb) ? 1 : 0;
            4'd13: r = (ua < ub) ? 1 : 0;
            4'd14: r = ub;
            4'd15: r = ua;
            default: r = 0;
        endcase
        return {r[15:0], (r == 0), r[15], c, v};
    endfunction

    function automatic logic [19:0] dut_word();
        return {bus.Output, bus.Zero, bus.Negative, bus.Carry, bus.Overflow};
    endfunction

    task automatic check(input string name, input logic [19:0] exp);
        logic [19:0] got;
        got = dut_word();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got out=%h znc v=%b%b%b%b, expected out=%h znc v=%b%b%b%b",
                     name, got[19:4], got[3], got[2], got[1], got[0],
                     exp[19:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic apply(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.Opcode = op;
        bus.A      = a;
        bus.B      = b;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    logic [19:0] prev_exp;
    logic [19:0] exp_w;
    logic [3:0]  rop;
    logic [15:0] ra, rb;

    initial begin
        errors = 0;
        checks = 0;

        vecs.push_back('{4'h0, 16'h0012, 16'h0003, 16'h0015, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h1, 16'h0008, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h1, 16'h00E7, 16'h00A1, 16'h0046, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'h1, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{4'h2, 16'h0002, 16'h0001, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h2, 16'h000F, 16'h0004, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h2, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'h2, 16'h0001, 16'h0011, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h9, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{4'h8, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h8, 16'h0003, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'hA, 16'h8001, 16'h0004, 16'h0018, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'hB, 16'h8001, 16'h0004, 16'h1800, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h3, 16'hFFFF, 16'h000F, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h3, 16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h4, 16'h00FF, 16'h0F0F, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h5, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h6, 16'h00FF, 16'h0F0F, 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{4'h7, 16'h00FF, 16'h0F0F, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{4'hC, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'hD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'hF, 16'h1234, 16'hABCD, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'hE, 16'h1234, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0});

        // Reset with arbitrary inputs, before any clock edge.
        bus.Opcode = 4'h0;
        bus.A      = 16'hFFFF;
        bus.B      = 16'h0001;
        rst_n      = 1'b0;
        #1;
        check("reset_initial", 20'h00000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", 20'h00000);

        @(negedge clk);
        rst_n = 1'b1;
        apply(4'h0, 16'h0001, 16'h0002);
        check("first_add_after_reset", {16'h0003, 4'b0000});

        // Directed table.
        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_op%h", i, vecs[i].op),
                  {vecs[i].out, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v});
        end

        // Inputs changing between edges must not disturb the registered result.
        apply(4'h0, 16'h7FFF, 16'h0001);
        #2;
        bus.Opcode = 4'h7;
        bus.A      = 16'h0000;
        #1;
        check("hold_between_edges", {16'h8000, 4'b0101});

        // Back-to-back across all encodings; also confirm the previous result
        // is still visible just before each capturing edge.
        prev_exp = dut_word();
        for (int k = 0; k < 64; k++) begin
            rop = 4'(k);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            @(negedge clk);
            bus.Opcode = rop;
            bus.A      = ra;
            bus.B      = rb;
            #1;
            check($sformatf("b2b_hold_%0d", k), prev_exp);
            exp_w = model(rop, ra, rb);
            @(posedge clk);
            #1;
            check($sformatf("b2b_op%h_a%h_b%h", rop, ra, rb), exp_w);
            prev_exp = exp_w;
        end

        // Mid-stream asynchronous reset pulse.
        apply(4'hF, 16'h9ABC, 16'h0000);
        check("pre_reset_value", {16'h9ABC, 4'b0100});
        #2;
        rst_n = 1'b0;
        #1;
        check("midstream_async_clear", 20'h00000);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'h1, 16'h0005, 16'h0005);
        check("sub_zero_after_reset", {16'h0000, 4'b1000});

        // Randomized vectors, biased toward corner operands sometimes.
        for (int k = 0; k < 400; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            apply(rop, ra, rb);
            check($sformatf("rand_op%h_a%h_b%h", rop, ra, rb), model(rop, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

16-bit registered arithmetic/logic unit for the 16-bit processor datapath. Each rising clock edge it samples two operands and a 4-bit opcode, computes one of 16 operations, and registers the 16-bit result plus four status flags. It sits between the register-file read ports and the writeback path; flags feed the branch/condition logic.

## Interface
- No parameters; data width fixed at 16 bits, opcode width fixed at 4 bits.
- clk  input  1  single system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- A  input  16  operand A (shift source for shift/rotate ops)
- B  input  16  operand B (B[3:0] is the shift/rotate amount)
- Opcode  input  4  operation select
- Output  output  16  registered result
- Zero  output  1  registered: result == 16'h0000
- Negative  output  1  registered: result[15]
- Carry  output  1  registered carry/borrow/shift-out, per opcode rules below
- Overflow  output  1  registered signed overflow, ADD/SUB only

## Operation
- 0000 ADD: A + B, modulo 2^16. Carry = bit-16 carry out. Overflow = A and B have the same sign and the result sign differs.
- 0001 SUB: A − B, modulo 2^16 (two's complement). Carry = borrow (1 when A < B unsigned). Overflow = A and B signs differ and the result sign differs from A.
- 0010 SLL: A << B[3:0], zero fill. Carry = last bit shifted out (A[16−n]); 0 when n = 0.
- 0011 AND: A & B.
- 0100 OR: A | B.
- 0101 XOR: A ^ B.
- 0110 NOR: ~(A | B).
- 0111 NOT: ~A; B ignored.
- 1000 SRL: A >> B[3:0], zero fill. Carry = last bit out (A[n−1]); 0 when n = 0.
- 1001 SRA: arithmetic right shift, sign fill, same Carry rule as SRL.
- 1010 ROL: rotate A left by B[3:0]. Carry = 0.
- 1011 ROR: rotate A right by B[3:0]. Carry = 0.
- 1100 SLT: 16'h0001 if signed A < signed B, else 16'h0000.
- 1101 SLTU: 16'h0001 if unsigned A < unsigned B, else 16'h0000.
- 1110 PASSB: B.
- 1111 PASSA: A.
- Shift/rotate amounts use only B[3:0]; B[15:4] are ignored, so a shift by 16 or more wraps to a shift by the amount mod 16.
- Carry = 0 for all opcodes not listed above as setting it. Overflow = 0 for every opcode except ADD/SUB.
- Zero and Negative are always derived from the 16-bit result being registered.
- No illegal opcodes; all 16 encodings are defined.

## Timing
- Fully synchronous datapath; all five outputs are flops updated on the rising edge of clk.
- Latency: 1 cycle. Inputs sampled at edge k drive the outputs immediately after edge k and hold them until edge k+1.
- No handshake and no enable; a new operation is accepted every cycle.
- The opcode, operands, and flags are all taken from the same edge; no mixing of cycles.
- Reset: rst_n low forces Output = 16'h0000, Zero = 0, Negative = 0, Carry = 0, Overflow = 0 immediately, independent of clk.
- Reset mid-operation discards the pending result. The first sample after deassertion is the first rising edge with rst_n high.
- Input changes between edges have no effect on the outputs.

## Test plan
- Reset: assert rst_n = 0 with arbitrary inputs -> all outputs 0 without a clock; release, then ADD A = 0001, B = 0002 -> Output = 0003 one edge later, Zero = 0.
- ADD/SUB: ADD 0012 + 0003 -> 0015. SUB 0008 − 0003 -> 0005. SUB 00E7 − 00A1 -> 0046, Carry = 0. ADD 7FFF + 0001 -> 8000, Overflow = 1, Negative = 1. ADD FFFF + 0001 -> 0000, Carry = 1, Zero = 1.
- Shifts: SLL 0002 by 1 -> 0004. SLL 000F by 4 -> 00F0. SLL 8001 by 1 -> 0002, Carry = 1. SRA 8000 by 15 -> FFFF. SLL 0001 with B = 0011 -> 0002 (only B[3:0] used).
- Logic: AND FFFF & 000F -> 000F. AND 0000 & 0001 -> 0000, Zero = 1. OR/XOR/NOR/NOT on 00FF and 0F0F -> 0FFF / 0FF0 / F000 / FF00.
- Compare/pass: SLT FFFF vs 0001 -> 0001. SLTU FFFF vs 0001 -> 0000. PASSA and PASSB return A and B unchanged.
- Back-to-back: change opcode every cycle across all 16 encodings -> each result appears exactly one edge after its inputs; mid-stream rst_n pulse -> outputs clear asynchronously.
